// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: hour/minute time-setting controller with blink, timeout and commit strobe.
// Optional macro CLOCK_SET_AUTOREPEAT_EN adds held-button auto-repeat of the increment.
module clock_set_ctrl #(
    parameter int HALF_SEC   = 50_000_000,
    parameter int TIMEOUT_S  = 30,
    parameter int REPEAT_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       tick_1hz,
    input  logic [7:0] cur_h,
    input  logic [7:0] cur_m,
    output logic [7:0] set_h,
    output logic [7:0] set_m,
    output logic       load,
    output logic       hold,
    output logic [3:0] blank,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_H = 2'b01, SET_M = 2'b10, COMMIT = 2'b11} state_t;

    localparam int BW = $clog2(HALF_SEC);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_SEC - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_S - 1);

    if (HALF_SEC < 2 || TIMEOUT_S < 1 || REPEAT_CYC < 1) begin : g_bad_param
        $error("clock_set_ctrl: parameter out of range");
    end

    state_t        state_q, state_d;
    logic          mode_prev_q, inc_prev_q;
    logic [7:0]    set_h_q, set_h_d, set_m_q, set_m_d;
    logic          load_q, load_d, hold_q, hold_d;
    logic [3:0]    blank_q, blank_d;
    logic          phase_q, phase_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mode_edge, inc_edge, inc_step, rep_fire, in_set, tmo_hit, bump, restart;

    // Saturate anything outside 00..max (including non-BCD digits) back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        r = (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
        return (v[7:4] > 4'd9 || v[3:0] > 4'd9 || r > max) ? 8'h00 : r;
    endfunction

    assign mode_edge = btn_mode & ~mode_prev_q;
    assign inc_edge  = btn_inc & ~inc_prev_q;
    assign in_set    = (state_q == SET_H) || (state_q == SET_M);
    assign tmo_hit   = in_set && tick_1hz && (tmo_q == TMO_LAST);
    assign inc_step  = inc_edge | rep_fire;
    assign bump      = inc_step && !mode_edge && !tmo_hit;

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RW = $clog2(2 * REPEAT_CYC);
    localparam logic [RW-1:0] REP_FIRST = RW'(2 * REPEAT_CYC - 1);
    localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_CYC - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d;
    logic          rep_run;

    assign rep_run  = in_set && btn_inc && !inc_edge;
    assign rep_fire = rep_run && (rep_q == (rep_first_q ? REP_FIRST : REP_NEXT));

    always_comb begin
        rep_d       = rep_run ? (rep_fire ? '0 : rep_q + RW'(1)) : '0;
        rep_first_d = rep_run ? (rep_first_q && !rep_fire) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            set_h_q     <= 8'h00;
            set_m_q     <= 8'h00;
            load_q      <= 1'b0;
            hold_q      <= 1'b0;
            blank_q     <= 4'b0000;
            phase_q     <= 1'b0;
            blink_q     <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode;
            inc_prev_q  <= btn_inc;
            set_h_q     <= set_h_d;
            set_m_q     <= set_m_d;
            load_q      <= load_d;
            hold_q      <= hold_d;
            blank_q     <= blank_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            tmo_q       <= tmo_d;
        end
    end

    // Timeout takes priority over a simultaneous mode edge.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN)
            state_d = mode_edge ? SET_H : RUN;
        else if (state_q == COMMIT)
            state_d = RUN;
        else if (tmo_hit)
            state_d = RUN;
        else if (mode_edge)
            state_d = (state_q == SET_H) ? SET_M : COMMIT;
    end

    always_comb begin
        set_h_d = set_h_q;
        set_m_d = set_m_q;
        if (state_q == RUN && mode_edge) begin
            set_h_d = cur_h;
            set_m_d = cur_m;
        end else if (bump && state_q == SET_H) begin
            set_h_d = bcd_inc(set_h_q, 8'h23);
        end else if (bump && state_q == SET_M) begin
            set_m_d = bcd_inc(set_m_q, 8'h59);
        end
        load_d  = (state_d == COMMIT);
        hold_d  = (state_d != RUN);
        tmo_d   = (!in_set || mode_edge || inc_step || tmo_hit) ? '0 : tmo_q + TW'(tick_1hz);
        restart = !in_set || (state_d != state_q) || inc_step;
        blink_d = (restart || blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);
        phase_d = restart ? 1'b0 : phase_q ^ (blink_q == BLINK_LAST);
        blank_d = !phase_d ? 4'b0000 : (state_d == SET_H) ? 4'b1100 : (state_d == SET_M) ? 4'b0011 : 4'b0000;
    end

    assign set_h = set_h_q;
    assign set_m = set_m_q;
    assign load  = load_q;
    assign hold  = hold_q;
    assign blank = blank_q;
    assign mode  = state_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed bench for clock_set_ctrl with HALF_SEC=4, TIMEOUT_S=3.
module tb_clock_set_ctrl;
    logic       clk = 1'b0, reset = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, tick_1hz = 1'b0;
    logic [7:0] cur_h = 8'h00, cur_m = 8'h00;
    logic [7:0] set_h, set_m;
    logic       load, hold;
    logic [3:0] blank;
    logic [1:0] mode;
    int         errors = 0, checks = 0, load_cnt = 0;

    clock_set_ctrl #(.HALF_SEC(4), .TIMEOUT_S(3), .REPEAT_CYC(8)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .tick_1hz(tick_1hz),
        .cur_h(cur_h), .cur_m(cur_m), .set_h(set_h), .set_m(set_m), .load(load), .hold(hold),
        .blank(blank), .mode(mode)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (load === 1'b1) load_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic press_mode;
        btn_mode = 1'b1; step(1); btn_mode = 1'b0; step(1);
    endtask

    task automatic press_inc;
        btn_inc = 1'b1; step(1); btn_inc = 1'b0; step(1);
    endtask

    task automatic pulse_tick;
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(1);
    endtask

    task automatic test_reset;
        reset = 1'b0; btn_mode = 1'b1; btn_inc = 1'b0;
        step(3);
        checks++;
        if ({set_h, set_m, load, hold, blank, mode} !== 26'd0) begin
            errors++;
            $display("FAIL reset_values got=%h exp=0", {set_h, set_m, load, hold, blank, mode});
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if ({mode, hold, load, blank} !== 8'd0) begin
                errors++;
                $display("FAIL held_mode_cycle%0d got=%h exp=00", i, {mode, hold, load, blank});
            end
        end
        btn_mode = 1'b0;
        step(1);
        press_inc;
        checks++;
        if ({mode, set_h} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL run_inc_ignored got=%h exp=000", {mode, set_h});
        end
    endtask

    task automatic test_wrap_commit;
        do_reset;
        cur_h = 8'h23; cur_m = 8'h59;
        btn_mode = 1'b1; step(1);
        checks++;
        if ({mode, hold, set_h, set_m} !== {2'b01, 1'b1, 8'h23, 8'h59}) begin
            errors++;
            $display("FAIL enter_set_h got=%h exp=%h", {mode, hold, set_h, set_m}, {2'b01, 1'b1, 8'h23, 8'h59});
        end
        btn_mode = 1'b0; step(1);
        press_inc;
        checks++;
        if (set_h !== 8'h00) begin
            errors++;
            $display("FAIL hour_wrap got=%h exp=00", set_h);
        end
        press_mode;
        press_inc;
        checks++;
        if ({mode, set_m} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL min_wrap got=%h exp=%h", {mode, set_m}, {2'b10, 8'h00});
        end
        btn_mode = 1'b1; step(1);
        checks++;
        if ({mode, load, hold, set_h, set_m} !== {2'b11, 1'b1, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL commit got=%h exp=%h", {mode, load, hold, set_h, set_m}, {2'b11, 1'b1, 1'b1, 16'h0000});
        end
        btn_mode = 1'b0; step(1);
        checks++;
        if ({mode, load, hold} !== 4'b0000) begin
            errors++;
            $display("FAIL after_commit got=%b exp=0000", {mode, load, hold});
        end
        step(1);
        checks++;
        if (load !== 1'b0) begin
            errors++;
            $display("FAIL load_one_cycle got=%b exp=0", load);
        end
    endtask

    task automatic test_bcd;
        do_reset;
        cur_h = 8'h09; cur_m = 8'h19;
        press_mode; press_inc;
        checks++;
        if (set_h !== 8'h10) begin
            errors++;
            $display("FAIL h09_inc got=%h exp=10", set_h);
        end
        press_mode; press_inc;
        checks++;
        if (set_m !== 8'h20) begin
            errors++;
            $display("FAIL m19_inc got=%h exp=20", set_m);
        end
        do_reset;
        cur_h = 8'h3A;
        press_mode;
        checks++;
        if (set_h !== 8'h3A) begin
            errors++;
            $display("FAIL capture_3a got=%h exp=3a", set_h);
        end
        press_inc;
        checks++;
        if (set_h !== 8'h00) begin
            errors++;
            $display("FAIL h3a_inc got=%h exp=00", set_h);
        end
    endtask

    task automatic test_blink;
        do_reset;
        cur_h = 8'h12;
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step(1);
            checks++;
            if (blank !== ((k >= 4) ? 4'b1100 : 4'b0000)) begin
                errors++;
                $display("FAIL blink_k%0d got=%b exp=%b", k, blank, (k >= 4) ? 4'b1100 : 4'b0000);
            end
        end
        btn_inc = 1'b1; step(1); btn_inc = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) step(1);
            checks++;
            if (blank !== ((j >= 4) ? 4'b1100 : 4'b0000)) begin
                errors++;
                $display("FAIL blink_restart_j%0d got=%b exp=%b", j, blank, (j >= 4) ? 4'b1100 : 4'b0000);
            end
        end
        checks++;
        if (set_h !== 8'h13) begin
            errors++;
            $display("FAIL blink_inc_value got=%h exp=13", set_h);
        end
    endtask

    task automatic test_timeout;
        int n0;
        do_reset;
        cur_h = 8'h10; cur_m = 8'h20;
        n0 = load_cnt;
        press_mode; press_mode;
        pulse_tick; pulse_tick;
        checks++;
        if ({mode, hold} !== 3'b101) begin
            errors++;
            $display("FAIL before_timeout got=%b exp=101", {mode, hold});
        end
        pulse_tick;
        checks++;
        if ({mode, hold, load, blank} !== 8'd0) begin
            errors++;
            $display("FAIL timeout got=%h exp=00", {mode, hold, load, blank});
        end
        press_mode; press_mode;
        pulse_tick;
        reset = 1'b0; step(1);
        checks++;
        if ({set_h, set_m, load, hold, blank, mode} !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=0", {set_h, set_m, load, hold, blank, mode});
        end
        reset = 1'b1; step(2);
        checks++;
        if ({mode, hold} !== 3'b000) begin
            errors++;
            $display("FAIL after_mid_reset got=%b exp=000", {mode, hold});
        end
        checks++;
        if (load_cnt !== n0) begin
            errors++;
            $display("FAIL no_load_in_timeout got=%0d exp=%0d", load_cnt, n0);
        end
    endtask

    task automatic test_simultaneous;
        do_reset;
        cur_h = 8'h12;
        press_mode;
        btn_mode = 1'b1; btn_inc = 1'b1; step(1);
        checks++;
        if ({mode, set_h} !== {2'b10, 8'h12}) begin
            errors++;
            $display("FAIL mode_beats_inc got=%h exp=%h", {mode, set_h}, {2'b10, 8'h12});
        end
        btn_mode = 1'b0; btn_inc = 1'b0; step(1);
    endtask

    initial begin
        test_reset;
        test_wrap_commit;
        test_bcd;
        test_blink;
        test_timeout;
        test_simultaneous;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
